// File: rtl/interrupt_controller_pkg.sv
// Shared CPU interrupt constants: line indices, debounce counter width and
// default debounce depth, plus the saturating counter step used by each line.
package interrupt_controller_pkg;

    localparam int LINE_ONE         = 0;
    localparam int LINE_TWO         = 1;
    localparam int NUM_LINES        = 2;
    localparam int CNT_W            = 4;
    localparam int DEBOUNCE_DEFAULT = 4;

    // Counter restarts whenever the synchronized level drops.
    function automatic logic [CNT_W-1:0] cnt_next(input logic lvl,
                                                  input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] sat);
        if (!lvl)
            return '0;
        if (cnt == sat)
            return cnt;
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/acknowledge/return handshake between the interrupt controller and
// the downstream exception unit.
interface interrupt_controller_if;

    logic interrupt_or_not_one;
    logic interrupt_or_not_two;
    logic ack_one;
    logic ack_two;
    logic eret;

    modport master (
        output interrupt_or_not_one,
        output interrupt_or_not_two,
        input  ack_one,
        input  ack_two,
        input  eret
    );

    modport slave (
        input  interrupt_or_not_one,
        input  interrupt_or_not_two,
        output ack_one,
        output ack_two,
        output eret
    );

endinterface

// File: rtl/interrupt_controller_irq_line_filter.sv
// One external request line: 2-flop synchronizer, saturating debounce counter
// and a single-cycle event when the counter first reaches DEBOUNCE.
module irq_line_filter
    import interrupt_controller_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    output logic irq_event
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] ARM = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

    // First flop output feeds only the second flop.
    always_comb begin
        sync1_d   = irq_async;
        sync2_d   = sync1_q;
        cnt_d     = cnt_next(sync2_q, cnt_q, SAT);
        irq_event = sync2_q && (cnt_q == ARM);
    end

endmodule

// File: rtl/interrupt_controller.sv
// Two-line prioritized interrupt controller: debounced events latch into
// pending, are acked into in_service, and unwind one nesting level per eret.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LINES-1:0]       irq_ext,
    input  logic [NUM_LINES-1:0]       int_mask,
    interrupt_controller_if.master     exc,
    output logic [NUM_LINES-1:0]       pending,
    output logic [NUM_LINES-1:0]       in_service,
    output logic [NUM_LINES-1:0]       overrun
);

    logic [NUM_LINES-1:0] evt;
    logic [NUM_LINES-1:0] req, grant, after_eret;
    logic [NUM_LINES-1:0] pending_q, pending_d;
    logic [NUM_LINES-1:0] in_service_q, in_service_d;
    logic [NUM_LINES-1:0] overrun_q, overrun_d;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        irq_line_filter #(.DEBOUNCE(DEBOUNCE)) u_filter (
            .clk       (clk),
            .rst       (rst),
            .irq_async (irq_ext[i]),
            .irq_event (evt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            in_service_q <= '0;
            overrun_q    <= '0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        req                = '0;
        req[LINE_TWO]      = pending_q[LINE_TWO] & int_mask[LINE_TWO] & ~in_service_q[LINE_TWO];
        // Line one waits while line two is being handled: no preemption of two.
        req[LINE_ONE]      = pending_q[LINE_ONE] & int_mask[LINE_ONE] & ~in_service_q[LINE_ONE]
                           & ~in_service_q[LINE_TWO];
        grant              = '0;
        grant[LINE_ONE]    = exc.ack_one & req[LINE_ONE];
        grant[LINE_TWO]    = exc.ack_two & req[LINE_TWO];

        // Return is resolved against the pre-ack nesting, then the ack is layered on.
        after_eret = in_service_q;
        if (exc.eret) begin
            if (in_service_q[LINE_TWO])
                after_eret[LINE_TWO] = 1'b0;
            else
                after_eret[LINE_ONE] = 1'b0;
        end
        in_service_d = after_eret | grant;

        // A fresh event in the ack cycle re-arms pending instead of counting as overrun.
        pending_d = evt | (pending_q & ~grant);
        overrun_d = overrun_q | (evt & pending_q & ~grant);
    end

    assign exc.interrupt_or_not_one = req[LINE_ONE];
    assign exc.interrupt_or_not_two = req[LINE_TWO];
    assign pending                  = pending_q;
    assign in_service               = in_service_q;
    assign overrun                  = overrun_q;

endmodule
